// File: rtl/riscv_32_instr_encoder.sv
// Streaming RV32 instruction encoder: packs R/I/U fields into 32-bit words,
// buffers them in a small FIFO and emits each with a sequential word address.
module riscv_32_instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_type,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [19:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     err_illegal,
    output logic                     mem_full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    localparam logic RUN  = 1'b0;
    localparam logic DONE = 1'b1;

    logic              state;
    logic [31:0]       mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       enc;
    logic              legal;
    logic              hs_in;
    logic              push;
    logic              pop;

    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (in_type)
            3'b000:  enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'b001:  enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            3'b010:  enc = {in_imm, in_rd, 7'b0110111};
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        in_ready  = (count != FULL_CNT) && (state == RUN);
        out_valid = (count != '0) && (state == RUN);
        out_instr = out_valid ? mem[rd_ptr] : '0;
        out_addr  = addr;
        mem_full  = (state == DONE);
    end

    // clear outranks both handshakes, so it is folded into the qualifiers
    assign hs_in = in_valid && in_ready && !clear;
    assign push  = hs_in && legal;
    assign pop   = out_valid && out_ready && !clear;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            addr        <= BASE;
            state       <= RUN;
            err_illegal <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            addr        <= BASE;
            state       <= RUN;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= hs_in && !legal;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                addr   <= addr + ADDR_W'(1);
                // the last word address wraps to 0 and locks the encoder
                if (addr == '1) begin
                    state <= DONE;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_32_instr_encoder.sv
// Scoreboard bench for riscv_32_instr_encoder: stimulus queues hand-computed
// words, a negedge monitor compares every output handshake against them.
module tb_riscv_32_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 4;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [19:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic        err_illegal;
    logic        mem_full;
    logic [$clog2(DEPTH):0] count;

    typedef struct {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    logic [ADDR_W-1:0] exp_addr;
    int                n_checks;
    int                n_fail;

    riscv_32_instr_encoder #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .err_illegal(err_illegal),
        .mem_full   (mem_full),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got 0x%08h @0x%0h expected no output", out_instr, out_addr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_instr", out_instr, mon_e.instr);
                chk("out_addr", 32'(out_addr), 32'(mon_e.addr));
            end
        end
    end

    task automatic push(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [19:0] imm, input logic [31:0] exp);
        int unsigned w = 0;
        in_valid  = 1'b1;
        in_type   = t;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_wait: got in_ready=0 expected in_ready=1 within 100 cycles");
        end else if (t <= 3'b010) begin
            exp_q.push_back('{instr: exp, addr: exp_addr});
            exp_addr++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned w = 0;
        while ((count != 0 || exp_q.size() != 0) && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain", 32'(count), 32'd0);
    endtask

    initial begin
        logic [31:0] word;
        int unsigned w;
        n_checks  = 0;
        n_fail    = 0;
        exp_addr  = '0;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_type   = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_imm    = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_mem_full", 32'(mem_full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // add x3,x1,x2: one-cycle latency into an empty FIFO
        out_ready = 1'b1;
        push(3'b000, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 20'h0, 32'h002081B3);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_instr", out_instr, 32'h002081B3);
        wait_drain();

        // addi then lui back-to-back, unused fields carry junk
        push(3'b001, 5'd1, 5'd0, 5'd7, 3'd0, 7'h55, 20'h00005, 32'h00500093);
        push(3'b010, 5'd5, 5'd31, 5'd31, 3'd7, 7'h7F, 20'h12345, 32'h123452B7);
        wait_drain();

        // backpressure: four sub words fill the FIFO, a fifth waits
        out_ready = 1'b0;
        push(3'b000, 5'd4, 5'd1, 5'd2, 3'd0, 7'h20, 20'h0, 32'h40208233);
        push(3'b000, 5'd5, 5'd1, 5'd2, 3'd0, 7'h20, 20'h0, 32'h402082B3);
        push(3'b000, 5'd6, 5'd1, 5'd2, 3'd0, 7'h20, 20'h0, 32'h40208333);
        push(3'b000, 5'd7, 5'd1, 5'd2, 3'd0, 7'h20, 20'h0, 32'h402083B3);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        fork
            push(3'b001, 5'd8, 5'd2, 5'd31, 3'd4, 7'h7F, 20'hFFFFF, 32'hFFF14413);
            begin
                for (int i = 0; i < 3; i++) begin
                    chk("hold_instr", out_instr, 32'h40208233);
                    chk("hold_addr", 32'(out_addr), 32'd3);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // illegal type: handshake completes, nothing queued, address kept
        push(3'b011, 5'd9, 5'd1, 5'd2, 3'd0, 7'd0, 20'h0, 32'h0);
        chk("ill_err_pulse", 32'(err_illegal), 32'd1);
        chk("ill_count", 32'(count), 32'd0);
        chk("ill_out_valid", 32'(out_valid), 32'd0);
        chk("ill_addr", 32'(out_addr), 32'd8);
        @(posedge clk);
        #1;
        chk("ill_err_drop", 32'(err_illegal), 32'd0);
        push(3'b010, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 20'hABCDE, 32'hABCDE537);
        wait_drain();

        // run addi xN,x0,N up to the last address so the counter wraps
        while (exp_addr != '0) begin
            word = {12'(exp_addr), 5'd0, 3'd0, 5'(exp_addr), 7'h13};
            push(3'b001, 5'(exp_addr), 5'd0, 5'd0, 3'd0, 7'd0, 20'(exp_addr), word);
        end
        w = 0;
        while (!mem_full && w < 10) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("done_mem_full", 32'(mem_full), 32'd1);
        chk("done_out_valid", 32'(out_valid), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        chk("done_addr_wrap", 32'(out_addr), 32'd0);
        chk("done_queue", 32'(exp_q.size()), 32'd0);

        // clear with a same-cycle illegal input, then with a legal one
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_type   = 3'b011;
        @(posedge clk);
        #1;
        in_type   = 3'b000;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        chk("clr_mem_full", 32'(mem_full), 32'd0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        chk("clr_addr", 32'(out_addr), 32'd0);
        chk("clr_err", 32'(err_illegal), 32'd0);
        exp_addr = '0;
        push(3'b000, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 20'h0, 32'h002081B3);
        wait_drain();

        // async reset with three queued words and a push in flight
        out_ready = 1'b0;
        push(3'b000, 5'd11, 5'd1, 5'd2, 3'd0, 7'd0, 20'h0, 32'h002085B3);
        push(3'b000, 5'd12, 5'd1, 5'd2, 3'd0, 7'd0, 20'h0, 32'h00208633);
        push(3'b000, 5'd13, 5'd1, 5'd2, 3'd0, 7'd0, 20'h0, 32'h002086B3);
        chk("pre_rst_count", 32'(count), 32'd3);
        in_valid = 1'b1;
        in_rd    = 5'd14;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_instr", out_instr, 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_addr", 32'(out_addr), 32'd0);
        exp_q.delete();
        exp_addr = '0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_count", 32'(count), 32'd0);

        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
